fw_coef_stream: RTL and testbench

//  Parametrised, writable coefficient store for BWN layer weights with a built-in read sequencer.
//  A start command streams rd_len beats from rd_base; each beat carries LANES consecutive coefficients.

---
 rtl/fw_coef_stream_if.sv | 14 +
 rtl/fw_coef_stream.sv | 173 +++++++++++++++++
 tb/tb_fw_coef_stream.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fw_coef_stream_if.sv
// Output beat stream from fw_coef_stream into the MAC array (valid/ready).
// The master side drives a beat of LANES coefficients; the slave side drives out_ready.
interface fw_coef_stream_if #(
  parameter int COEF_W = 3,
  parameter int LANES  = 4
);
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic [LANES*COEF_W-1:0]   out_coef;

  modport master (output out_valid, output out_coef, output out_last, input out_ready);
  modport slave  (input out_valid, input out_coef, input out_last, output out_ready);
endinterface

// File: rtl/fw_coef_stream.sv
// Writable BWN coefficient store with a read sequencer streaming LANES coefficients per beat.
// Optional macro FW_COEF_PARITY_EN adds a stored parity bit per word and a sticky par_err output.
//
//  state | meaning
//  IDLE  | waiting for start; writes still accepted
//  RUN   | streaming beats until the out_last beat is accepted
module fw_coef_stream #(
  parameter int  COEF_W = 3,
  parameter int  DEPTH  = 40,
  parameter int  LANES  = 4,
  parameter int  LEN_W  = 12,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [COEF_W-1:0] wr_data,
`ifdef FW_COEF_PARITY_EN
  input  logic              wr_par,
`endif
  input  logic              start,
  input  logic [AW-1:0]     rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              busy,
  output logic              done,
`ifdef FW_COEF_PARITY_EN
  output logic              par_err,
`endif
  fw_coef_stream_if.master  out_if
);

`ifdef FW_COEF_PARITY_EN
  localparam int MW = COEF_W + 1;
`else
  localparam int MW = COEF_W;
`endif
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LANES_C = (AW+1)'(LANES);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  logic [MW-1:0] mem_q [DEPTH];

  state_t                  state_q, state_d;
  logic [AW-1:0]           ptr_q, ptr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [LANES*COEF_W-1:0] coef_q, coef_d;
  logic                    done_q, done_d;
  logic                    par_err_q, par_err_d;

  logic [LANES*COEF_W-1:0] lane_coef;
  logic [LANES-1:0]        lane_perr;
  logic [AW:0]             ptr_sum;
  logic [AW:0]             ptr_next;
  logic                    base_ok;
  logic                    load;

  // Memory write; read happens combinationally from the pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_C)) begin
`ifdef FW_COEF_PARITY_EN
      mem_q[wr_addr] <= {wr_par, wr_data};
`else
      mem_q[wr_addr] <= wr_data;
`endif
    end
  end

  // ptr < DEPTH and k < LANES <= DEPTH, so one conditional subtract gives the modulo.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [AW:0]   sum;
    logic [AW:0]   idx;
    logic [MW-1:0] word;
    assign sum  = {1'b0, ptr_q} + (AW+1)'(k);
    assign idx  = (sum >= DEPTH_C) ? (sum - DEPTH_C) : sum;
    assign word = mem_q[idx[AW-1:0]];
    assign lane_coef[k*COEF_W +: COEF_W] = word[COEF_W-1:0];
`ifdef FW_COEF_PARITY_EN
    assign lane_perr[k] = ^word;
`else
    assign lane_perr[k] = 1'b0;
`endif
  end

  assign ptr_sum  = {1'b0, ptr_q} + LANES_C;
  assign ptr_next = (ptr_sum >= DEPTH_C) ? (ptr_sum - DEPTH_C) : ptr_sum;
  assign base_ok  = ({1'b0, rd_base} < DEPTH_C);
  assign load     = (state_q == RUN) && (!valid_q || out_if.out_ready) && (rem_q != '0);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    valid_d   = valid_q;
    last_d    = last_q;
    coef_d    = coef_q;
    done_d    = 1'b0;
    par_err_d = par_err_q;

    case (state_q)
      IDLE: begin
        if (start && base_ok) begin
          par_err_d = 1'b0;
          if (rd_len != '0) begin
            state_d = RUN;
            ptr_d   = rd_base;
            rem_d   = rd_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid_q && out_if.out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        if (load) begin
          valid_d = 1'b1;
          coef_d  = lane_coef;
          ptr_d   = ptr_next[AW-1:0];
          rem_d   = rem_q - ONE_LEN;
          last_d  = (rem_q == ONE_LEN);
          if (|lane_perr) par_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      coef_q    <= '0;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      coef_q    <= coef_d;
      done_q    <= done_d;
      par_err_q <= par_err_d;
    end
  end

  assign busy             = (state_q == RUN);
  assign done             = done_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign out_if.out_coef  = coef_q;
`ifdef FW_COEF_PARITY_EN
  assign par_err = par_err_q;
`else
  logic unused_par;
  assign unused_par = par_err_q;
`endif

endmodule

// File: tb/tb_fw_coef_stream.sv
// Directed bench for fw_coef_stream with defaults; memory preloaded with mem[i] = i % 8.
module tb_fw_coef_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [2:0]  wr_data;
  logic        wr_par;
  logic        start;
  logic [5:0]  rd_base;
  logic [11:0] rd_len;
  logic        busy;
  logic        done;
  logic        par_err;

  int n_tests = 0;
  int n_fail  = 0;

  fw_coef_stream_if #(.COEF_W(3), .LANES(4)) out_if ();

  fw_coef_stream dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`ifdef FW_COEF_PARITY_EN
    .wr_par  (wr_par),
`endif
    .start   (start),
    .rd_base (rd_base),
    .rd_len  (rd_len),
    .busy    (busy),
    .done    (done),
`ifdef FW_COEF_PARITY_EN
    .par_err (par_err),
`endif
    .out_if  (out_if.master)
  );

`ifndef FW_COEF_PARITY_EN
  assign par_err = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int                 base;
    int                 len;
    logic [2:0][11:0]   beats;
  } vec_t;

  function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
    logic [2:0] l0, l1, l2, l3;
    l0 = a[2:0]; l1 = b[2:0]; l2 = c[2:0]; l3 = d[2:0];
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[5:0];
    wr_data = d[2:0];
    wr_par  = ^d[2:0];
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic run_cmd(input int base, input int len, input logic [2:0][11:0] beats, input string tag);
    @(negedge clk);
    start = 1'b1; rd_base = base[5:0]; rd_len = len[11:0];
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 1);
    check({tag, " early_valid"}, 32'(out_if.out_valid), 0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("%s valid%0d", tag, i), 32'(out_if.out_valid), 1);
      check($sformatf("%s coef%0d", tag, i), 32'(out_if.out_coef), 32'(beats[i]));
      check($sformatf("%s last%0d", tag, i), 32'(out_if.out_last), (i == len-1) ? 1 : 0);
    end
    @(negedge clk);
    check({tag, " done"}, 32'(done), 1);
    check({tag, " busy_end"}, 32'(busy), 0);
    check({tag, " valid_end"}, 32'(out_if.out_valid), 0);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 0);
  endtask

  vec_t vecs [5];

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_par = 1'b0;
    start = 1'b0; rd_base = '0; rd_len = '0; out_if.out_ready = 1'b1;

    vecs[0] = '{base: 0,  len: 2, beats: {12'h0, pk(4,5,6,7), pk(0,1,2,3)}};
    vecs[1] = '{base: 38, len: 2, beats: {12'h0, pk(2,3,4,5), pk(6,7,0,1)}};
    vecs[2] = '{base: 10, len: 3, beats: {pk(2,3,4,5), pk(6,7,0,1), pk(2,3,4,5)}};
    vecs[3] = '{base: 36, len: 1, beats: {12'h0, 12'h0, pk(4,5,6,7)}};
    vecs[4] = '{base: 39, len: 1, beats: {12'h0, 12'h0, pk(7,0,1,2)}};

    repeat (2) @(negedge clk);
    check("rst busy",  32'(busy), 0);
    check("rst valid", 32'(out_if.out_valid), 0);
    check("rst last",  32'(out_if.out_last), 0);
    check("rst done",  32'(done), 0);
    check("rst coef",  32'(out_if.out_coef), 0);
    check("rst par",   32'(par_err), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) wr(i, i % 8);

    for (int v = 0; v < 5; v++)
      run_cmd(vecs[v].base, vecs[v].len, vecs[v].beats, $sformatf("vec%0d", v));

    // backpressure on beat 1
    @(negedge clk);
    start = 1'b1; rd_base = 6'd0; rd_len = 12'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("bp coef0", 32'(out_if.out_coef), 32'(pk(0,1,2,3)));
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp hold_valid%0d", i), 32'(out_if.out_valid), 1);
      check($sformatf("bp hold_coef%0d", i), 32'(out_if.out_coef), 32'(pk(0,1,2,3)));
      check($sformatf("bp hold_last%0d", i), 32'(out_if.out_last), 0);
    end
    out_if.out_ready = 1'b1;
    @(negedge clk);
    check("bp coef1", 32'(out_if.out_coef), 32'(pk(4,5,6,7)));
    check("bp last1", 32'(out_if.out_last), 1);
    @(negedge clk);
    check("bp done", 32'(done), 1);

    // rd_len == 0
    @(negedge clk);
    start = 1'b1; rd_base = 6'd3; rd_len = 12'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0 done",  32'(done), 1);
    check("len0 busy",  32'(busy), 0);
    check("len0 valid", 32'(out_if.out_valid), 0);
    @(negedge clk);
    check("len0 done_pulse", 32'(done), 0);
    check("len0 valid2", 32'(out_if.out_valid), 0);

    // rd_base out of range
    start = 1'b1; rd_base = 6'd40; rd_len = 12'd2;
    @(negedge clk);
    start = 1'b0;
    check("base40 busy", 32'(busy), 0);
    check("base40 done", 32'(done), 0);
    @(negedge clk);
    check("base40 valid", 32'(out_if.out_valid), 0);

    // start while busy is ignored
    start = 1'b1; rd_base = 6'd0; rd_len = 12'd2;
    @(negedge clk);
    rd_base = 6'd8; rd_len = 12'd1;
    check("sbusy busy", 32'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    check("sbusy coef0", 32'(out_if.out_coef), 32'(pk(0,1,2,3)));
    @(negedge clk);
    check("sbusy coef1", 32'(out_if.out_coef), 32'(pk(4,5,6,7)));
    check("sbusy last1", 32'(out_if.out_last), 1);
    @(negedge clk);
    check("sbusy done", 32'(done), 1);
    @(negedge clk);
    check("sbusy idle", 32'(busy), 0);

    // write coinciding with beat load returns old data
    start = 1'b1; rd_base = 6'd0; rd_len = 12'd1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 6'd1; wr_data = 3'd7; wr_par = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("rbw old", 32'(out_if.out_coef), 32'(pk(0,1,2,3)));
    run_cmd(0, 1, {12'h0, 12'h0, pk(0,7,2,3)}, "rbw new");
    wr(1, 1);

    // synchronous reset mid-command
    start = 1'b1; rd_base = 6'd0; rd_len = 12'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mrst coef0", 32'(out_if.out_coef), 32'(pk(0,1,2,3)));
    @(negedge clk);
    check("mrst coef1", 32'(out_if.out_coef), 32'(pk(4,5,6,7)));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst valid", 32'(out_if.out_valid), 0);
    check("mrst busy",  32'(busy), 0);
    check("mrst done",  32'(done), 0);
    @(negedge clk);
    check("mrst no_done", 32'(done), 0);
    run_cmd(0, 2, vecs[0].beats, "mrst after");

`ifdef FW_COEF_PARITY_EN
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 3'd5; wr_par = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b1; rd_base = 6'd4; rd_len = 12'd1;
    @(negedge clk);
    start = 1'b0;
    check("par pre", 32'(par_err), 0);
    @(negedge clk);
    check("par valid", 32'(out_if.out_valid), 1);
    check("par set", 32'(par_err), 1);
    repeat (3) @(negedge clk);
    check("par sticky", 32'(par_err), 1);
    start = 1'b1; rd_base = 6'd0; rd_len = 12'd1;
    @(negedge clk);
    start = 1'b0;
    check("par clear", 32'(par_err), 0);
    repeat (3) @(negedge clk);
    wr(5, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
